div_unit: RTL and testbench

- Iterative RV32M divide/remainder unit for the EX stage. Executes DIV, DIVU, REM and REMU.
- Its result and destination index drive the register-file write port (IN, INADDRESS, WRITE) through writeback.
- Uses a radix-2 restoring algorithm: one quotient bit per cycle, with single-cycle fast paths for divide-by-zero and signed overflow.
- The hazard unit stalls the pipeline while BUSY is high.

---
 rtl/div_unit.sv | 188 ++++++++++++++++++
 tb/tb_div_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit -- iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
//
// Radix-2 restoring divider. It retires one quotient bit per cycle.
// Divide-by-zero and signed overflow (MIN / -1) complete through a
// single-cycle fast path. The result and destination index feed the
// register-file write port through writeback.
//
// Ports:
//   CLK     in   rising-edge clock
//   RESET   in   asynchronous active-high reset
//   START   in   request pulse, sampled only in IDLE or DONE
//   FUNCT   in   [1:0] 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   DATA1   in   [XLEN-1:0] dividend (rs1)
//   DATA2   in   [XLEN-1:0] divisor (rs2)
//   RD_IN   in   [4:0] destination register index
//   KILL    in   synchronous flush, abandons any operation
//   BUSY    out  high while iterating (CALC)
//   VALID   out  one-cycle result strobe (never for x0)
//   RESULT  out  [XLEN-1:0] quotient or remainder, held until next DONE
//   RD_OUT  out  [4:0] destination index of RESULT

module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [1:0]      FUNCT,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic [4:0]      RD_IN,
    input  logic            KILL,
    output logic            BUSY,
    output logic            VALID,
    output logic [XLEN-1:0] RESULT,
    output logic [4:0]      RD_OUT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // Two's-complement negate, wrapping modulo 2^XLEN (MIN_NEG maps to itself).
    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + ONE;
    endfunction

    state_t            r_state;
    logic              r_busy;
    logic              r_valid;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_out;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_funct;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_rem;    // partial remainder
    logic [XLEN-1:0]   r_quo;    // dividend shifts out of the top while quotient bits enter at the bottom
    logic [XLEN-1:0]   r_dvs;    // divisor magnitude
    logic              r_squo;   // quotient must be negated
    logic              r_srem;   // remainder must be negated

    // Operand preparation at accept
    logic              w_signed;
    logic              w_s1;
    logic              w_s2;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic              w_div0;
    logic              w_ovf;
    logic [XLEN-1:0]   w_fast;

    // One restoring step
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_qbit;
    logic [XLEN-1:0]   w_rem_next;
    logic [XLEN-1:0]   w_quo_next;
    logic [XLEN-1:0]   w_raw;
    logic              w_neg;
    logic [XLEN-1:0]   w_final;

    always_comb begin
        w_signed = ~FUNCT[0];
        w_s1     = w_signed & DATA1[XLEN-1];
        w_s2     = w_signed & DATA2[XLEN-1];
        w_mag1   = w_s1 ? negate(DATA1) : DATA1;
        w_mag2   = w_s2 ? negate(DATA2) : DATA2;
        w_div0   = (DATA2 == '0);
        w_ovf    = w_signed && (DATA1 == MIN_NEG) && (DATA2 == '1);

        // Division by zero wins over overflow (divisor -1 is nonzero anyway).
        if (w_div0)
            w_fast = FUNCT[1] ? DATA1 : '1;
        else
            w_fast = FUNCT[1] ? '0 : MIN_NEG;
    end

    always_comb begin
        w_shift    = {r_rem, r_quo[XLEN-1]};
        w_diff     = w_shift - {1'b0, r_dvs};
        // A clear borrow bit means the trial subtraction stayed non-negative.
        w_qbit     = ~w_diff[XLEN];
        w_rem_next = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
        w_quo_next = {r_quo[XLEN-2:0], w_qbit};

        // Final result is formed from this step's outputs so it can be
        // registered on the last iteration edge.
        w_raw      = r_funct[1] ? w_rem_next : w_quo_next;
        w_neg      = r_funct[1] ? r_srem : r_squo;
        w_final    = w_neg ? negate(w_raw) : w_raw;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
            r_cnt    <= '0;
            r_funct  <= '0;
            r_rd     <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_squo   <= 1'b0;
            r_srem   <= 1'b0;
        end else if (KILL) begin
            // Flush beats any START; RESULT/RD_OUT keep the last committed value.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(XLEN - 1)) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_valid  <= (r_rd != 5'd0);
                        r_result <= w_final;
                        r_rd_out <= r_rd;
                    end
                end

                default: begin
                    // IDLE and DONE both accept; DONE otherwise falls back to IDLE.
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    if (START) begin
                        r_funct <= FUNCT;
                        r_rd    <= RD_IN;
                        r_squo  <= w_s1 ^ w_s2;
                        r_srem  <= w_s1;
                        if (w_div0 || w_ovf) begin
                            r_state  <= S_DONE;
                            r_valid  <= (RD_IN != 5'd0);
                            r_result <= w_fast;
                            r_rd_out <= RD_IN;
                        end else begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                            r_rem   <= '0;
                            r_quo   <= w_mag1;
                            r_dvs   <= w_mag2;
                        end
                    end
                end
            endcase
        end
    end

    assign BUSY   = r_busy;
    assign VALID  = r_valid;
    assign RESULT = r_result;
    assign RD_OUT = r_rd_out;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- directed self-checking bench for div_unit.
// Latency convention: "lat" is the number of clock edges after the accept
// edge at which VALID is first seen (0 = visible right after the accept edge).

module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  funct;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rdin;
    logic        kill;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] F_DIV  = 2'b00;
    localparam logic [1:0] F_DIVU = 2'b01;
    localparam logic [1:0] F_REM  = 2'b10;
    localparam logic [1:0] F_REMU = 2'b11;

    div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .CLK    (clk),
        .RESET  (rst),
        .START  (start),
        .FUNCT  (funct),
        .DATA1  (d1),
        .DATA2  (d2),
        .RD_IN  (rdin),
        .KILL   (kill),
        .BUSY   (busy),
        .VALID  (valid),
        .RESULT (result),
        .RD_OUT (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
        $fatal(1, "watchdog");
    end

    // Issues one operation and observes 40 cycles from the accept edge.
    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output int nbusy,
                          output int nvalid, output logic [31:0] res, output logic [4:0] rdo);
        @(posedge clk); #1;
        start = 1'b1; funct = f; d1 = a; d2 = b; rdin = rd;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; nbusy = 0; nvalid = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (busy) nbusy++;
            if (valid) begin
                nvalid++;
                if (lat < 0) lat = k;
            end
        end
        res = result;
        rdo = rd_out;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; kill = 1'b0; funct = 2'b00; d1 = '0; d2 = '0; rdin = '0;
        #12;
        n_checks++;
        if ({busy, valid, result, rd_out} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b valid=%b result=%h rd=%0d required all 0", busy, valid, result, rd_out);
        end
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b valid=%b required 0 0", busy, valid);
        end
    endtask

    task automatic test_divu();
        int lat, nb, nv; logic [31:0] res; logic [4:0] rdo;
        run_op(F_DIVU, 32'd100, 32'd7, 5'd5, lat, nb, nv, res, rdo);
        n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL divu_latency: got %0d required 32", lat); end
        n_checks++; if (nb !== 32) begin n_fail++; $display("FAIL divu_busy_cycles: got %0d required 32", nb); end
        n_checks++; if (nv !== 1) begin n_fail++; $display("FAIL divu_valid_count: got %0d required 1", nv); end
        n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL divu_result: got %h required %h", res, 32'd14); end
        n_checks++; if (rdo !== 5'd5) begin n_fail++; $display("FAIL divu_rd: got %0d required 5", rdo); end
        run_op(F_REMU, 32'd100, 32'd7, 5'd6, lat, nb, nv, res, rdo);
        n_checks++; if (res !== 32'd2) begin n_fail++; $display("FAIL remu_result: got %h required %h", res, 32'd2); end
        n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL remu_latency: got %0d required 32", lat); end
        run_op(F_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd7, lat, nb, nv, res, rdo);
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_max_by_1: got %h required ffffffff", res); end
    endtask

    task automatic test_signed();
        int lat, nb, nv; logic [31:0] res; logic [4:0] rdo;
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd8, lat, nb, nv, res, rdo);
        n_checks++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg7_2: got %h required fffffffd", res); end
        n_checks++; if (nv !== 1 || lat !== 32) begin n_fail++; $display("FAIL div_neg7_2_timing: valids=%0d lat=%0d required 1 32", nv, lat); end
        run_op(F_REM, 32'hFFFF_FFF9, 32'd2, 5'd9, lat, nb, nv, res, rdo);
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_neg7_2: got %h required ffffffff", res); end
        run_op(F_REM, 32'd7, 32'hFFFF_FFFE, 5'd10, lat, nb, nv, res, rdo);
        n_checks++; if (res !== 32'd1) begin n_fail++; $display("FAIL rem_7_neg2: got %h required 00000001", res); end
        run_op(F_DIV, 32'h8000_0000, 32'd2, 5'd11, lat, nb, nv, res, rdo);
        n_checks++; if (res !== 32'hC000_0000) begin n_fail++; $display("FAIL div_min_2: got %h required c0000000", res); end
    endtask

    task automatic test_fast_path();
        int lat, nb, nv; logic [31:0] res; logic [4:0] rdo;
        run_op(F_DIVU, 32'h1234, 32'd0, 5'd12, lat, nb, nv, res, rdo);
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by0: got %h required ffffffff", res); end
        n_checks++; if (lat !== 0 || nb !== 0 || nv !== 1) begin n_fail++; $display("FAIL divu_by0_timing: lat=%0d busy=%0d valids=%0d required 0 0 1", lat, nb, nv); end
        n_checks++; if (rdo !== 5'd12) begin n_fail++; $display("FAIL divu_by0_rd: got %0d required 12", rdo); end
        run_op(F_REM, 32'h1234, 32'd0, 5'd13, lat, nb, nv, res, rdo);
        n_checks++; if (res !== 32'h1234) begin n_fail++; $display("FAIL rem_by0: got %h required 00001234", res); end
        n_checks++; if (lat !== 0 || nb !== 0 || nv !== 1) begin n_fail++; $display("FAIL rem_by0_timing: lat=%0d busy=%0d valids=%0d required 0 0 1", lat, nb, nv); end
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, lat, nb, nv, res, rdo);
        n_checks++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf: got %h required 80000000", res); end
        n_checks++; if (lat !== 0 || nb !== 0 || nv !== 1) begin n_fail++; $display("FAIL div_ovf_timing: lat=%0d busy=%0d valids=%0d required 0 0 1", lat, nb, nv); end
        run_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, lat, nb, nv, res, rdo);
        n_checks++; if (res !== 32'd0) begin n_fail++; $display("FAIL rem_ovf: got %h required 00000000", res); end
    endtask

    task automatic test_back_to_back();
        int k1, k2, tot;
        logic [31:0] r1; logic [4:0] o1;
        k1 = -1; k2 = -1; tot = 0; r1 = '0; o1 = '0;
        @(posedge clk); #1;
        start = 1'b1; funct = F_DIVU; d1 = 32'd100; d2 = 32'd7; rdin = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40 && k1 < 0; k++) begin
            @(posedge clk); #1;
            if (k == 10) begin
                start = 1'b1; funct = F_DIVU; d1 = 32'd50; d2 = 32'd5; rdin = 5'd4;
            end else begin
                start = 1'b0;
            end
            if (valid) begin tot++; k1 = k; r1 = result; o1 = rd_out; end
        end
        n_checks++; if (k1 !== 32) begin n_fail++; $display("FAIL b2b_first_latency: got %0d required 32", k1); end
        n_checks++; if (r1 !== 32'd14 || o1 !== 5'd3) begin n_fail++; $display("FAIL b2b_first_result: got %h rd %0d required 0000000e rd 3", r1, o1); end
        if (k1 >= 0) begin
            // Still in the DONE cycle of the first operation.
            start = 1'b1; funct = F_REMU; d1 = 32'd100; d2 = 32'd7; rdin = 5'd6;
            @(posedge clk); #1;
            start = 1'b0;
            for (int k = 0; k <= 40; k++) begin
                if (k > 0) begin @(posedge clk); #1; end
                if (valid) begin
                    tot++;
                    if (k2 < 0) k2 = k;
                end
            end
        end
        n_checks++; if (k2 !== 32) begin n_fail++; $display("FAIL b2b_second_latency: got %0d required 32", k2); end
        n_checks++; if (result !== 32'd2 || rd_out !== 5'd6) begin n_fail++; $display("FAIL b2b_second_result: got %h rd %0d required 00000002 rd 6", result, rd_out); end
        n_checks++; if (tot !== 2) begin n_fail++; $display("FAIL b2b_valid_count: got %0d required 2", tot); end
    endtask

    task automatic test_kill();
        int lat, nb, nv; logic [31:0] res; logic [4:0] rdo;
        run_op(F_DIVU, 32'd100, 32'd7, 5'd5, lat, nb, nv, res, rdo);
        n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL kill_setup: got %h required 0000000e", res); end
        @(posedge clk); #1;
        start = 1'b1; funct = F_DIV; d1 = 32'd1000; d2 = 32'd3; rdin = 5'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1; kill = 1'b1;
        @(posedge clk); #1; kill = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy: got %b required 0", busy); end
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (valid) nv++;
        end
        n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL kill_no_valid: got %0d valids required 0", nv); end
        n_checks++; if (result !== 32'd14 || rd_out !== 5'd5) begin n_fail++; $display("FAIL kill_hold: got %h rd %0d required 0000000e rd 5", result, rd_out); end
        // KILL and START together: nothing accepted.
        start = 1'b1; kill = 1'b1; funct = F_DIVU; d1 = 32'd5; d2 = 32'd0; rdin = 5'd8;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        n_checks++; if (valid !== 1'b0 || busy !== 1'b0 || rd_out !== 5'd5) begin n_fail++; $display("FAIL kill_start_same: valid=%b busy=%b rd=%0d required 0 0 5", valid, busy, rd_out); end
    endtask

    task automatic test_reset_mid();
        int nv;
        @(posedge clk); #1;
        start = 1'b1; funct = F_DIVU; d1 = 32'd100; d2 = 32'd7; rdin = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #4; rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, valid, result, rd_out} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: busy=%b valid=%b result=%h rd=%0d required all 0", busy, valid, result, rd_out);
        end
        #10; rst = 1'b0;
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (valid || busy) nv++;
        end
        n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL reset_mid_release: got %0d active cycles required 0", nv); end
    endtask

    task automatic test_rd_zero();
        int lat, nb, nv; logic [31:0] res; logic [4:0] rdo;
        run_op(F_DIVU, 32'd9, 32'd3, 5'd0, lat, nb, nv, res, rdo);
        n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL rd0_valid: got %0d valids required 0", nv); end
        n_checks++; if (res !== 32'd3 || rdo !== 5'd0) begin n_fail++; $display("FAIL rd0_result: got %h rd %0d required 00000003 rd 0", res, rdo); end
        n_checks++; if (nb !== 32) begin n_fail++; $display("FAIL rd0_busy_cycles: got %0d required 32", nb); end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_fast_path();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        test_rd_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
